// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer in front of a byte-addressable,
// little-endian data memory with a registered (one-cycle) read port.
//
// Loads take IDLE->LD_ADDR->LD_DATA->RESP. Word stores go straight to ST_WR.
// Byte/half stores read the containing word, merge the new low byte/half and
// write the whole word back (RMW_ADDR->RMW_MERGE->ST_WR). Rejected requests
// go straight to RESP with resp_err set and never touch memory.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses are rejected as errors; otherwise they proceed.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_store            1 = store, 0 = load
//   req_funct3           RV32I width/sign code
//   req_addr, req_wdata  byte address, store data
//   resp_valid           one-cycle completion pulse
//   resp_data, resp_err  extended load data (0 for stores/errors), error flag
//   mem_addr, mem_wdata  memory byte address and full write word
//   mem_write            memory write strobe
//   mem_rdata            memory read data, valid one cycle after mem_addr

module load_store_unit #(
   parameter int unsigned MEM_BYTES = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] MaxAddr = 32'(MEM_BYTES - 4);

   typedef enum logic [2:0] {
      StIdle, StLdAddr, StLdData, StRmwAddr, StRmwMerge, StStWr, StResp
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [15:0] st_data_q, st_data_d;  // only the low half is ever merged
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_write_q, mem_write_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_data_q, resp_data_d;

   logic        f3_ok;
   logic        misalign;
   logic        req_err;
   logic [31:0] load_ext;
   logic [31:0] merged;

   // Request legality, evaluated on the raw request in IDLE.
   always_comb begin
      if (req_store) begin
         f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
      end else begin
         f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                 (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   // Memory is byte-addressable, so misaligned accesses simply proceed.
   assign misalign = 1'b0;
`endif

   assign req_err = !f3_ok || (req_addr > MaxAddr) || misalign;

   // Load extension on the word returned at mem_addr (byte 0 = addressed byte).
   always_comb begin
      case (funct3_q)
         3'b000:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         3'b001:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         3'b100:  load_ext = {24'h0, mem_rdata[7:0]};
         3'b101:  load_ext = {16'h0, mem_rdata[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   // funct3_q[0] distinguishes sh (001) from sb (000).
   assign merged = funct3_q[0] ? {mem_rdata[31:16], st_data_q[15:0]}
                               : {mem_rdata[31:8], st_data_q[7:0]};

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      funct3_d     = funct3_q;
      st_data_d    = st_data_q;
      mem_wdata_d  = mem_wdata_q;
      mem_write_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_data_d  = 32'h0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d    = req_addr;
               funct3_d  = req_funct3;
               st_data_d = req_wdata[15:0];
               if (req_err) begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (!req_store) begin
                  state_d = StLdAddr;
               end else if (req_funct3 == 3'b010) begin
                  state_d     = StStWr;
                  mem_wdata_d = req_wdata;
                  mem_write_d = 1'b1;
               end else begin
                  state_d = StRmwAddr;
               end
            end
         end
         StLdAddr:  state_d = StLdData;
         StLdData: begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_data_d  = load_ext;
         end
         StRmwAddr: state_d = StRmwMerge;
         StRmwMerge: begin
            state_d     = StStWr;
            mem_wdata_d = merged;
            mem_write_d = 1'b1;
         end
         StStWr: begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
         end
         StResp:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         addr_q       <= 32'h0;
         funct3_q     <= 3'b000;
         st_data_q    <= 16'h0;
         mem_wdata_q  <= 32'h0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         funct3_q     <= funct3_d;
         st_data_q    <= st_data_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_write_q  <= mem_write_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_data  = resp_data_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_write  = mem_write_q;

endmodule
